// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, drives a synchronous imem and queues returned words in a 2-entry FIFO.
// Latency: request in t, data in t+1, valid on if_* in t+2. Issue is throttled so count+inflight never exceeds 2 (stall fills to 2, then imem_req=0).
module fetch_unit #(
  parameter int             l        = 32,
  parameter int             n        = 8,
  parameter logic [l-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic [n-1:0] imem_addr,
  output logic         imem_req,
  input  logic [l-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect,
  input  logic [l-1:0] redirect_pc,
  output logic [l-1:0] if_instr,
  output logic [l-1:0] if_pc,
  output logic         if_valid
);

  localparam logic [l-1:0] NOP     = l'(32'h0000_0013);
  localparam logic [l-1:0] PC_STEP = l'(4);

  logic [l-1:0] r_fetch_pc;
  logic [l-1:0] r_req_pc;
  logic         r_inflight;
  logic [1:0]   r_count;
  logic         r_head;
  logic [l-1:0] r_q_pc  [2];
  logic [l-1:0] r_q_ins [2];

  logic         w_valid;
  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  logic         w_tail;
  logic [2:0]   w_occ;
  logic [l-1:0] w_redir_pc;
  logic         w_unused_bits;

  assign w_unused_bits = ^redirect_pc[1:0];
  assign w_redir_pc    = {redirect_pc[l-1:2], 2'b00};

  // The reset gate keeps the head invisible in the reset cycle even when entries remain.
  assign w_valid = (r_count != 2'd0) && !reset;
  assign w_pop   = w_valid && !stall && !redirect;
  assign w_push  = r_inflight && !redirect && !reset;
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue = !reset && !redirect && (w_occ < (3'd2 + {2'b00, w_pop}));

  // Issue throttling guarantees count <= 1 whenever a response lands, so head+count (mod 2) is a free slot.
  assign w_tail = r_head ^ r_count[0];

  assign imem_req  = !reset && (redirect || w_issue);
  assign imem_addr = redirect ? w_redir_pc[n-1:0] : {r_fetch_pc[n-1:2], 2'b00};

  assign if_valid = w_valid;
  assign if_instr = w_valid ? r_q_ins[r_head] : NOP;
  assign if_pc    = w_valid ? r_q_pc[r_head]  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= {RESET_PC[l-1:2], 2'b00};
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= w_redir_pc + PC_STEP;
      r_req_pc   <= w_redir_pc;
      r_inflight <= 1'b1;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
        r_req_pc   <= r_fetch_pc;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[w_tail]  <= r_req_pc;
      r_q_ins[w_tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected consumed PCs, plus cycle-exact checks on timing.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -3;
  logic [31:0] exp_q [$];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {8'hA5, a, ~a, 8'h13};
  endfunction

  // Synchronous memory: word for the requested address next cycle, junk otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    reset       = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  // Monitor: every consumed head must be the next expected PC with its matching word.
  always @(negedge clk) begin
    if (!reset && if_valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected (cycle %0d): got pc %h expected no output", cyc, if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e);
        check("sb_instr", if_instr, word_of(e[7:0]));
      end
    end
  end

  initial begin
    logic r, s, rd;
    logic [31:0] rpc;
    logic        exp_vld;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h13);
    check("rst_pc", if_pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);

    for (int c = 0; c <= 35; c++) begin
      r = 1'b0; s = 1'b0; rd = 1'b0; rpc = '0;
      if (c >= 4 && c <= 8) s = 1'b1;
      if (c == 12) s = 1'b1;
      if (c == 13) begin rd = 1'b1; rpc = 32'h0000_0040; end
      if (c == 18) begin s = 1'b1; rd = 1'b1; rpc = 32'h0000_0043; end
      if (c == 23) r = 1'b1;
      if (c == 28) begin rd = 1'b1; rpc = 32'hFFFF_FFFC; end
      if (c >= 34) s = 1'b1;

      case (c)
        0:  begin exp_q.push_back(32'h0); exp_q.push_back(32'h4); end
        9:  begin exp_q.push_back(32'h8); exp_q.push_back(32'hC); exp_q.push_back(32'h10); end
        13, 18: begin exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48); end
        24: begin exp_q.push_back(32'h0); exp_q.push_back(32'h4); end
        28: begin
          exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
          exp_q.push_back(32'h4);         exp_q.push_back(32'h8);
        end
        default: ;
      endcase

      drive(r, s, rd, rpc);

      exp_vld = !(c == 0 || c == 1 || c == 14 || c == 19 || c == 23 || c == 24 || c == 25 || c == 29);
      check("valid", {31'b0, if_valid}, {31'b0, exp_vld});

      case (c)
        0: begin
          check("first_req", {31'b0, imem_req}, 32'd1);
          check("first_addr", {24'h0, imem_addr}, 32'h0);
          check("idle_instr", if_instr, 32'h13);
          check("idle_pc", if_pc, 32'h0);
        end
        2:  check("first_pc", if_pc, 32'h0);
        4, 5, 6, 7, 8: begin
          check("stall_pc", if_pc, 32'h8);
          check("stall_instr", if_instr, word_of(8'h08));
          check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        9: begin
          check("release_req", {31'b0, imem_req}, 32'd1);
          check("release_addr", {24'h0, imem_addr}, 32'h10);
        end
        10: check("release_pc1", if_pc, 32'hC);
        11: check("release_pc2", if_pc, 32'h10);
        13: begin
          check("redir_req", {31'b0, imem_req}, 32'd1);
          check("redir_addr", {24'h0, imem_addr}, 32'h40);
        end
        14: check("bubble_instr", if_instr, 32'h13);
        15: check("redir_pc", if_pc, 32'h40);
        18: begin
          check("redir_stall_req", {31'b0, imem_req}, 32'd1);
          check("redir_align_addr", {24'h0, imem_addr}, 32'h40);
        end
        20: check("redir_stall_pc", if_pc, 32'h40);
        23: check("reset_req", {31'b0, imem_req}, 32'd0);
        24: begin
          check("restart_addr", {24'h0, imem_addr}, 32'h0);
          check("restart_pc0", if_pc, 32'h0);
        end
        26: check("restart_pc", if_pc, 32'h0);
        28: check("wrap_addr0", {24'h0, imem_addr}, 32'hFC);
        29: begin
          check("wrap_req", {31'b0, imem_req}, 32'd1);
          check("wrap_addr1", {24'h0, imem_addr}, 32'h00);
        end
        30: check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        31: check("wrap_pc1", if_pc, 32'h0);
        default: ;
      endcase
    end

    check("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
